// File: rtl/psum_accumulate_buffer.sv
// psum_accumulate_buffer: PE-side partial-sum join/accumulate stage.
// Joins local and router psums (saturating) and queues results for the router.
module psum_accumulate_buffer #(
    parameter int DATA_WIDTH = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [1:0]                        acc_mode_i,
    input  logic [DATA_WIDTH-1:0]             data_local_i,
    input  logic                              enable_local_i,
    output logic                              ready_local_o,
    input  logic [DATA_WIDTH-1:0]             data_psum_i,
    input  logic                              enable_psum_i,
    output logic                              ready_psum_o,
    output logic [DATA_WIDTH-1:0]             data_o,
    output logic                              enable_o,
    input  logic                              ready_i,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count_o,
    output logic                              sat_flag_o,
    input  logic                              clear_sat_i
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        MODE_LOCAL = 2'd0,
        MODE_JOIN  = 2'd1,
        MODE_PSUM  = 2'd2,
        MODE_HOLD  = 2'd3
    } acc_mode_e;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_sat;

    acc_mode_e             w_mode;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ovf;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_sat_val;
    logic [DATA_WIDTH-1:0] w_wr_data;

    assign w_mode  = acc_mode_e'(acc_mode_i);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);

    // Sign-extended sum one bit wider; overflow when the top two bits differ.
    assign w_sum = {data_local_i[DATA_WIDTH-1], data_local_i}
                 + {data_psum_i[DATA_WIDTH-1], data_psum_i};
    assign w_ovf = w_sum[DATA_WIDTH] ^ w_sum[DATA_WIDTH-1];

    // Clamp the wide sum to the signed range of the data width.
    always_comb begin
        w_sat_val = w_sum[DATA_WIDTH-1:0];
        if (w_ovf) begin
            if (w_sum[DATA_WIDTH]) begin
                w_sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                w_sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end
    end

    // Input readies from registered count, mode and the partner enable.
    always_comb begin
        ready_local_o = 1'b0;
        ready_psum_o  = 1'b0;
        if (!rst_i) begin
            case (w_mode)
                MODE_LOCAL: begin
                    ready_local_o = !w_full;
                end
                MODE_JOIN: begin
                    ready_local_o = !w_full && enable_psum_i;
                    ready_psum_o  = !w_full && enable_local_i;
                end
                MODE_PSUM: begin
                    ready_psum_o = !w_full;
                end
                default: begin
                    ready_local_o = 1'b0;
                    ready_psum_o  = 1'b0;
                end
            endcase
        end
    end

    // Accept decision and the word that gets written for it.
    always_comb begin
        w_push    = 1'b0;
        w_wr_data = data_local_i;
        case (w_mode)
            MODE_LOCAL: begin
                w_push    = enable_local_i && ready_local_o;
                w_wr_data = data_local_i;
            end
            MODE_JOIN: begin
                w_push    = enable_local_i && ready_local_o;
                w_wr_data = w_sat_val;
            end
            MODE_PSUM: begin
                w_push    = enable_psum_i && ready_psum_o;
                w_wr_data = data_psum_i;
            end
            default: begin
                w_push    = 1'b0;
                w_wr_data = data_local_i;
            end
        endcase
    end

    assign w_pop = !w_empty && ready_i;

    // Storage array; contents are only observable while counted valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the depth.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky saturation flag; a new clamp wins over a clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sat <= 1'b0;
        end else if (w_push && (w_mode == MODE_JOIN) && w_ovf) begin
            r_sat <= 1'b1;
        end else if (clear_sat_i) begin
            r_sat <= 1'b0;
        end
    end

    assign enable_o     = !w_empty;
    assign data_o       = w_empty ? '0 : r_mem[r_rd_ptr];
    assign fifo_count_o = r_count;
    assign sat_flag_o   = r_sat;

endmodule
